// File: rtl/sb_mtrx_pkg.sv
// Shared constants for the matrix frame-buffer write port.
// Holds the register word addresses, the CTRL register bit positions
// and the value returned for reads of unmapped addresses.
package sb_mtrx_pkg;
  localparam logic [15:0] ADDR_PTR   = 16'd8;
  localparam logic [15:0] ADDR_DATA  = 16'd9;
  localparam logic [15:0] ADDR_CTRL  = 16'd10;
  localparam logic [15:0] ADDR_LEVEL = 16'd11;
  localparam logic [15:0] ADDR_ID    = 16'd12;

  // CTRL write bits
  localparam int CTRL_BSEL    = 0;
  localparam int CTRL_SWAP    = 1;
  localparam int CTRL_OVF_CLR = 3;
  // CTRL read bits
  localparam int CTRL_PEND    = 1;
  localparam int CTRL_BCUR    = 2;
  localparam int CTRL_OVF     = 3;
  localparam int CTRL_EMPTY   = 4;

  localparam logic [15:0] RD_UNMAPPED = 16'hffff;
endpackage

// File: rtl/sb_mtrx_port_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports: clk, rst (async, active high), push/din, pop, dout (head entry,
// zero while empty), full, empty, level (entry count).
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Zero while empty so the head outputs have a defined reset value
  // without having to reset the storage array.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/sb_mtrx_port.sv
// sb_mtrx_port: system-bus slave feeding the matrix frame buffer.
// Ports: clk, rst (async, active high); sb_wr/sb_rd/sb_addr/sb_wr_data
// bus strobes, sb_rd_data registered read data; fb_wr_valid/ready/addr/data
// write FIFO head toward the frame buffer; buf_select displayed-buffer
// request, swap_ack frame-boundary pulse, buf_current displayed buffer.
module sb_mtrx_port
  import sb_mtrx_pkg::*;
#(
  parameter int          NUM_SCRATCH = 4,
  parameter int          ADDR_W      = 14,
  parameter int          PIX_W       = 12,
  parameter int          DEPTH       = 2048,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] ID          = 16'hfeed
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sb_wr,
  input  logic              sb_rd,
  input  logic [15:0]       sb_addr,
  input  logic [15:0]       sb_wr_data,
  output logic [15:0]       sb_rd_data,
  output logic              fb_wr_valid,
  input  logic              fb_wr_ready,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [PIX_W-1:0]  fb_wr_data,
  output logic              buf_select,
  input  logic              swap_ack,
  input  logic              buf_current
);
  localparam int EW = ADDR_W + PIX_W;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SCRATCH-1:0][15:0] scratch;
  logic [ADDR_W-1:0]            ptr, ptr_inc;
  logic [ADDR_W:0]              ptr_ld;
  logic                         swap_pend, overflow;
  logic [EW-1:0]                head;
  logic                         full, empty;
  logic [LW-1:0]                level;
  logic                         is_data, push, ctrl_wr, swap_req, toggle;
  logic [15:0]                  ctrl_rd, rd_mux;

  assign is_data  = sb_wr && (sb_addr == ADDR_DATA);
  assign push     = is_data && !full;
  assign ctrl_wr  = sb_wr && (sb_addr == ADDR_CTRL);
  assign swap_req = ctrl_wr && sb_wr_data[CTRL_SWAP];
  assign toggle   = swap_ack && swap_pend;
  assign ptr_ld   = {1'b0, sb_wr_data[ADDR_W-1:0]};
  assign ptr_inc  = (ptr == ADDR_W'(DEPTH-1)) ? '0 : ptr + 1'b1;

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({ptr, sb_wr_data[PIX_W-1:0]}),
    .pop   (fb_wr_ready),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign fb_wr_valid = !empty;
  assign fb_wr_addr  = head[EW-1:PIX_W];
  assign fb_wr_data  = head[PIX_W-1:0];

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[CTRL_BSEL]  = buf_select;
    ctrl_rd[CTRL_PEND]  = swap_pend;
    ctrl_rd[CTRL_BCUR]  = buf_current;
    ctrl_rd[CTRL_OVF]   = overflow;
    ctrl_rd[CTRL_EMPTY] = empty;
  end

  always_comb begin
    rd_mux = RD_UNMAPPED;
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (sb_addr == 16'(i)) rd_mux = scratch[i];
    case (sb_addr)
      ADDR_PTR:   rd_mux = 16'(ptr);
      ADDR_DATA:  rd_mux = '0;
      ADDR_CTRL:  rd_mux = ctrl_rd;
      ADDR_LEVEL: rd_mux = 16'(level);
      ADDR_ID:    rd_mux = ID;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch    <= '0;
      ptr        <= '0;
      swap_pend  <= 1'b0;
      overflow   <= 1'b0;
      buf_select <= 1'b0;
      sb_rd_data <= RD_UNMAPPED;
    end else begin
      // Read samples pre-write state, so a colliding write is not visible.
      if (sb_rd) sb_rd_data <= rd_mux;
      if (sb_wr) begin
        for (int i = 0; i < NUM_SCRATCH; i++)
          if (sb_addr == 16'(i)) scratch[i] <= sb_wr_data;
        if (sb_addr == ADDR_PTR)
          ptr <= (ptr_ld >= (ADDR_W+1)'(DEPTH)) ? '0 : sb_wr_data[ADDR_W-1:0];
      end
      if (push) ptr <= ptr_inc;
      if (is_data && full) overflow <= 1'b1;
      else if (ctrl_wr && sb_wr_data[CTRL_OVF_CLR]) overflow <= 1'b0;
      // Frame toggle has priority over a direct buf_select write.
      if (toggle)       buf_select <= ~buf_select;
      else if (ctrl_wr) buf_select <= sb_wr_data[CTRL_BSEL];
      // A new request in the same cycle as a toggle stays pending.
      if (swap_req)    swap_pend <= 1'b1;
      else if (toggle) swap_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sb_mtrx_port.sv
// Scoreboard bench for sb_mtrx_port: a queue-based reference model
// produces expected read data and frame-buffer beats; a negedge monitor
// compares them against whatever the DUT presents.
module tb_sb_mtrx_port;
  localparam int NS  = 4;
  localparam int AW  = 14;
  localparam int PW  = 12;
  localparam int DEP = 2048;
  localparam int FD  = 8;

  logic          clk = 0, rst = 1;
  logic          sb_wr = 0, sb_rd = 0;
  logic [15:0]   sb_addr = 0, sb_wr_data = 0;
  logic [15:0]   sb_rd_data;
  logic          fb_wr_valid, fb_wr_ready = 0;
  logic [AW-1:0] fb_wr_addr;
  logic [PW-1:0] fb_wr_data;
  logic          buf_select, swap_ack = 0, buf_current = 0;

  sb_mtrx_port #(.NUM_SCRATCH(NS), .ADDR_W(AW), .PIX_W(PW), .DEPTH(DEP),
                 .FIFO_DEPTH(FD), .ID(16'hfeed)) dut (
    .clk(clk), .rst(rst), .sb_wr(sb_wr), .sb_rd(sb_rd), .sb_addr(sb_addr),
    .sb_wr_data(sb_wr_data), .sb_rd_data(sb_rd_data),
    .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .buf_select(buf_select), .swap_ack(swap_ack), .buf_current(buf_current));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // reference model state
  int             mptr;
  logic [15:0]    mscr [NS];
  bit             mbsel, mpend, movf;
  logic [AW+PW-1:0] mq[$];
  // scoreboard queues and current-state expectations
  logic [15:0]    rd_q[$];
  logic [AW+PW-1:0] beat_q[$];
  bit             exp_valid, exp_bsel, rd_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    mq.delete(); rd_q.delete(); beat_q.delete();
    mptr = 0; mbsel = 0; mpend = 0; movf = 0;
    for (int i = 0; i < NS; i++) mscr[i] = 16'h0;
    exp_valid = 0; exp_bsel = 0; rd_seen = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a < NS)  return mscr[a];
    if (a == 8)  return 16'(mptr);
    if (a == 9)  return 16'h0;
    if (a == 10) return {11'b0, mq.size() == 0, movf, buf_current, mpend, mbsel};
    if (a == 11) return 16'(mq.size());
    if (a == 12) return 16'hfeed;
    return 16'hffff;
  endfunction

  // One bus cycle: update the model from its pre-cycle state, drive the
  // DUT, and advance to just after the next rising edge.
  task automatic step(input bit wr, input bit rd, input logic [15:0] a,
                      input logic [15:0] wd, input bit ack);
    bit full_pre, tog, cw;
    int v;
    exp_valid = mq.size() > 0;
    exp_bsel  = mbsel;
    if (rd) rd_q.push_back(model_read(a));
    full_pre = (mq.size() == FD);
    if (fb_wr_ready && mq.size() > 0) beat_q.push_back(mq.pop_front());
    cw  = wr && a == 10;
    tog = ack && mpend;
    if (wr) begin
      if (a < NS) mscr[a] = wd;
      else if (a == 8) begin
        v = int'(wd) % (1 << AW);
        mptr = (v >= DEP) ? 0 : v;
      end else if (a == 9) begin
        if (full_pre) movf = 1;
        else begin
          mq.push_back({AW'(mptr), wd[PW-1:0]});
          mptr = (mptr + 1) % DEP;
        end
      end else if (cw && wd[3]) movf = 0;
    end
    if (tog) mbsel = !mbsel;
    else if (cw) mbsel = wd[0];
    if (cw && wd[1]) mpend = 1;
    else if (tog) mpend = 0;
    sb_wr = wr; sb_rd = rd; sb_addr = a; sb_wr_data = wd; swap_ack = ack;
    @(posedge clk); #1;
    sb_wr = 0; sb_rd = 0; swap_ack = 0;
  endtask

  task automatic wr_(input logic [15:0] a, input logic [15:0] d); step(1, 0, a, d, 0); endtask
  task automatic rd_(input logic [15:0] a); step(0, 1, a, 0, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0); endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("fb_wr_valid", 32'(fb_wr_valid), 32'(exp_valid));
      chk("buf_select", 32'(buf_select), 32'(exp_bsel));
      if (rd_seen) begin
        if (rd_q.size() == 0) chk("rd_q_underrun", 1, 0);
        else chk("sb_rd_data", 32'(sb_rd_data), 32'(rd_q.pop_front()));
      end
      if (fb_wr_valid && fb_wr_ready) begin
        if (beat_q.size() == 0) chk("unexpected_beat", 32'({fb_wr_addr, fb_wr_data}), 0);
        else chk("fb_beat", 32'({fb_wr_addr, fb_wr_data}), 32'(beat_q.pop_front()));
      end
      rd_seen = sb_rd;
    end
  end

  initial begin
    mreset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", 32'(sb_rd_data), 32'hffff);
    chk("rst_valid", 32'(fb_wr_valid), 0);
    chk("rst_addr", 32'(fb_wr_addr), 0);
    chk("rst_bsel", 32'(buf_select), 0);
    rst = 0;

    // scratch and ID
    wr_(0, 16'h1234); wr_(3, 16'habcd);
    rd_(0); rd_(3); rd_(12); rd_(13); rd_(9); rd_(5);

    // burst with pointer wrap
    fb_wr_ready = 1;
    wr_(8, 16'd2046);
    wr_(9, 1); wr_(9, 2); wr_(9, 3);
    rd_(8); idle(2);
    wr_(8, 16'd3000); rd_(8);

    // backpressure and overflow
    fb_wr_ready = 0;
    wr_(8, 16'd100);
    for (int i = 0; i < 10; i++) wr_(9, 16'(16'h50 + i));
    rd_(11); rd_(10); rd_(8);
    fb_wr_ready = 1;
    idle(10);
    wr_(10, 16'h8); rd_(10);

    // swap
    wr_(10, 16'h2); idle(4);
    step(0, 0, 0, 0, 1); rd_(10);
    step(0, 0, 0, 0, 1); rd_(10);

    // simultaneous events
    wr_(10, 16'h3); step(1, 0, 10, 16'h3, 1); rd_(10);
    wr_(10, 16'h2); step(1, 0, 10, 16'h0, 1); rd_(10);
    step(0, 1, 10, 0, 0);

    // reset with entries queued
    fb_wr_ready = 0;
    for (int i = 0; i < 5; i++) wr_(9, 16'(i + 7));
    idle(1);
    rst = 1; #1;
    chk("async_rst_valid", 32'(fb_wr_valid), 0);
    chk("async_rst_bsel", 32'(buf_select), 0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_rd_data", 32'(sb_rd_data), 32'hffff);
    rst = 0;
    rd_(11); rd_(10);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a, d;
      int op;
      fb_wr_ready = ($urandom_range(0, 2) != 0);
      buf_current = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 13));
      if ($urandom_range(0, 2) == 0) a = 16'd9;
      d = 16'($urandom);
      if (a == 8 && $urandom_range(0, 1) == 1) d = 16'($urandom_range(2040, 2047));
      op = $urandom_range(0, 3);
      step(op >= 2, op == 1, a, d, $urandom_range(0, 5) == 0);
    end
    fb_wr_ready = 1;
    idle(FD + 4);
    chk("beats_drained", 32'(beat_q.size()), 0);
    chk("reads_drained", 32'(rd_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
